// File: rtl/video_pkg.sv
// video_pkg: shared VGA timing defaults, render mode encodings and luma coefficients.
package video_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  typedef enum logic [1:0] {
    MODE_COLOR   = 2'd0,
    MODE_BIN     = 2'd1,
    MODE_BIN_INV = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;
  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;
  // Weighted sum peaks at 64088 for RGB565 inputs, so 16 bits never overflow.
  function automatic logic [7:0] luma8(input logic [15:0] pix);
    logic [15:0] sum;
    sum = LUMA_R * {8'd0, pix[15:11], 3'd0}
        + LUMA_G * {8'd0, pix[10:5], 2'd0}
        + LUMA_B * {8'd0, pix[4:0], 3'd0};
    return sum[15:8];
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA pixel/line counters and raw active-low syncs.
module vga_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
)(
  input  logic       clk25,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_n,
  output logic       vsync_n
);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
  end
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end
  assign h_cnt   = h_cnt_q;
  assign v_cnt   = v_cnt_q;
  assign hsync_n = !(h_cnt_q >= HS_START && h_cnt_q < HS_END);
  assign vsync_n = !(v_cnt_q >= VS_START && v_cnt_q < VS_END);
endmodule

// File: rtl/vga_window_render.sv
// vga_window_render: centred camera window on VGA, colour or thresholded luma, 2-cycle pipeline.
// Define WIN_BORDER_EN to draw a 1-pixel white border just outside the window.
module vga_window_render
  import video_pkg::*;
#(
  parameter int WIN_W    = 320,
  parameter int WIN_H    = 240,
  parameter int ADDR_W   = 17,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
)(
  input  logic              clk25,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [7:0]        threshold,
  output logic [ADDR_W-1:0] frame_addr,
  input  logic [15:0]       frame_pixel,
  output logic [3:0]        vga_red,
  output logic [3:0]        vga_green,
  output logic [3:0]        vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [9:0]        HCnt,
  output logic [9:0]        VCnt,
  output logic              frame_start
);
  localparam logic [9:0] X0 = 10'((H_ACTIVE - WIN_W) / 2);
  localparam logic [9:0] X1 = 10'((H_ACTIVE - WIN_W) / 2 + WIN_W);
  localparam logic [9:0] Y0 = 10'((V_ACTIVE - WIN_H) / 2);
  localparam logic [9:0] Y1 = 10'((V_ACTIVE - WIN_H) / 2 + WIN_H);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIN_W * WIN_H - 1);
  logic hs_raw_n, vs_raw_n, in_win, border1;
  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk25   (clk25),
    .rst_n   (rst_n),
    .h_cnt   (HCnt),
    .v_cnt   (VCnt),
    .hsync_n (hs_raw_n),
    .vsync_n (vs_raw_n)
  );
  assign in_win      = HCnt >= X0 && HCnt < X1 && VCnt >= Y0 && VCnt < Y1;
  assign frame_start = rst_n && HCnt == '0 && VCnt == '0;
  mode_e             mode_q, mode_d;
  logic [7:0]        thr_q, thr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              win1_q, win1_d, hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              bin_mode, bin;
  // Address saturates on the last window pixel so it holds until the next frame.
  always_comb begin
    mode_d   = frame_start ? mode_e'(mode) : mode_q;
    thr_d    = frame_start ? threshold : thr_q;
    addr_d   = frame_start ? '0 : (in_win && addr_q != ADDR_LAST) ? addr_q + ADDR_W'(1) : addr_q;
    win1_d   = in_win;
    hs1_d    = hs_raw_n;
    vs1_d    = vs_raw_n;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    bin_mode = mode_q == MODE_BIN || mode_q == MODE_BIN_INV;
    bin      = (luma8(frame_pixel) > thr_q) ^ (mode_q == MODE_BIN_INV);
    rgb_d    = !win1_q ? {12{border1}}
             : bin_mode ? {12{bin}}
             : {frame_pixel[15:12], frame_pixel[10:7], frame_pixel[4:1]};
  end
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      mode_q <= MODE_COLOR;
      thr_q  <= '0;
      addr_q <= '0;
      win1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      rgb_q  <= '0;
    end else begin
      mode_q <= mode_d;
      thr_q  <= thr_d;
      addr_q <= addr_d;
      win1_q <= win1_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      hs2_q  <= hs2_d;
      vs2_q  <= vs2_d;
      rgb_q  <= rgb_d;
    end
  end
`ifdef WIN_BORDER_EN
  // Ring = window grown by one pixel each side minus the window, clipped to active area.
  logic [10:0] hp, vp;
  logic        border_d, border1_q;
  assign hp       = {1'b0, HCnt} + 11'd1;
  assign vp       = {1'b0, VCnt} + 11'd1;
  assign border_d = !in_win && HCnt < 10'(H_ACTIVE) && VCnt < 10'(V_ACTIVE)
                 && hp >= {1'b0, X0} && hp <= {1'b0, X1} + 11'd1
                 && vp >= {1'b0, Y0} && vp <= {1'b0, Y1} + 11'd1;
  always_ff @(posedge clk25) begin
    if (!rst_n) border1_q <= 1'b0;
    else        border1_q <= border_d;
  end
  assign border1 = border1_q;
`else
  assign border1 = 1'b0;
`endif
  assign frame_addr = addr_q;
  assign {vga_red, vga_green, vga_blue} = rgb_q;
  assign vga_hsync = hs2_q;
  assign vga_vsync = vs2_q;
endmodule

// File: tb/tb_vga_window_render.sv
// tb_vga_window_render: directed table-driven checks on a scaled-down timing (48x24 total, 8x4 window).
module tb_vga_window_render;
  localparam int WW = 8, WH = 4;
  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 16, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
`ifdef WIN_BORDER_EN
  localparam logic [11:0] BRD = 12'hFFF;
`else
  localparam logic [11:0] BRD = 12'h000;
`endif
  logic        clk25 = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  threshold = 8'd0;
  logic [15:0] frame_pixel = 16'h0000;
  logic [16:0] frame_addr;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        vga_hsync, vga_vsync, frame_start;
  logic [9:0]  HCnt, VCnt;
  int tests = 0;
  int fails = 0;

  vga_window_render #(
    .WIN_W(WW), .WIN_H(WH), .ADDR_W(17),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk25       (clk25),
    .rst_n       (rst_n),
    .mode        (mode),
    .threshold   (threshold),
    .frame_addr  (frame_addr),
    .frame_pixel (frame_pixel),
    .vga_red     (vga_red),
    .vga_green   (vga_green),
    .vga_blue    (vga_blue),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .HCnt        (HCnt),
    .VCnt        (VCnt),
    .frame_start (frame_start)
  );

  always #5 clk25 = ~clk25;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  m;
    logic [7:0]  t;
    logic [15:0] p;
    int          h;
    int          v;
    logic [11:0] rgb;
    int          a;
  } vec_t;
  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(HCnt == 10'(h) && VCnt == 10'(v)) && n < 3000) begin
      @(negedge clk25);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL wait_pos(%0d,%0d): got timeout after %0d cycles want position reached", h, v, n);
    end
  endtask

  task automatic next_pos(input int h, input int v);
    step(1);
    wait_pos(h, v);
  endtask

  task automatic rgb_chk(input string name, input logic [11:0] exp);
    chk(name, {20'd0, vga_red, vga_green, vga_blue}, {20'd0, exp});
  endtask

  task automatic reset_at(input int h, input int v, input string tag);
    next_pos(h, v);
    rst_n = 1'b0;
    step(1);
    chk({tag, "_hcnt"}, {22'd0, HCnt}, 0);
    chk({tag, "_vcnt"}, {22'd0, VCnt}, 0);
    chk({tag, "_addr"}, {15'd0, frame_addr}, 0);
    rgb_chk({tag, "_rgb"}, 12'h000);
    chk({tag, "_hsync"}, {31'd0, vga_hsync}, 1);
    chk({tag, "_vsync"}, {31'd0, vga_vsync}, 1);
    chk({tag, "_fstart"}, {31'd0, frame_start}, 0);
    step(2);
    rst_n = 1'b1;
    #1;
    chk({tag, "_rel_fstart"}, {31'd0, frame_start}, 1);
    chk({tag, "_rel_hcnt"}, {22'd0, HCnt}, 0);
    step(1);
    chk({tag, "_rel_hcnt1"}, {22'd0, HCnt}, 1);
    chk({tag, "_rel_fstart1"}, {31'd0, frame_start}, 0);
  endtask

  initial begin
    int hs_low, vs_low, fs_at;
    vecs[0]  = '{2'd0, 8'd0,   16'hF800, 12, 6,  12'hF00, 0};
    vecs[1]  = '{2'd0, 8'd0,   16'hF800, 19, 9,  12'hF00, 31};
    vecs[2]  = '{2'd0, 8'd0,   16'hF800, 11, 6,  BRD,     0};
    vecs[3]  = '{2'd0, 8'd0,   16'hF800, 20, 8,  BRD,     24};
    vecs[4]  = '{2'd0, 8'd0,   16'hF800, 25, 8,  12'h000, 24};
    vecs[5]  = '{2'd0, 8'd0,   16'h07E0, 13, 7,  12'h0F0, 9};
    vecs[6]  = '{2'd0, 8'd0,   16'h001F, 14, 8,  12'h00F, 18};
    vecs[7]  = '{2'd0, 8'd0,   16'h1234, 15, 9,  12'h14A, 27};
    vecs[8]  = '{2'd1, 8'd100, 16'hFFFF, 12, 6,  12'hFFF, 0};
    vecs[9]  = '{2'd1, 8'd100, 16'h0000, 13, 6,  12'h000, 1};
    vecs[10] = '{2'd2, 8'd100, 16'hFFFF, 12, 7,  12'h000, 8};
    vecs[11] = '{2'd2, 8'd100, 16'h0000, 12, 7,  12'hFFF, 8};
    vecs[12] = '{2'd3, 8'd0,   16'hF800, 12, 6,  12'hF00, 0};
    vecs[13] = '{2'd1, 8'd128, 16'h8410, 16, 8,  12'h000, 20};
    vecs[14] = '{2'd1, 8'd127, 16'h8410, 16, 8,  12'hFFF, 20};
    vecs[15] = '{2'd2, 8'd128, 16'h8410, 16, 8,  12'hFFF, 20};
    vecs[16] = '{2'd1, 8'd100, 16'hFFFF, 11, 6,  BRD,     0};
    vecs[17] = '{2'd0, 8'd0,   16'hF800, 40, 12, 12'h000, 31};
    vecs[18] = '{2'd0, 8'd0,   16'hF800, 15, 10, BRD,     31};
    vecs[19] = '{2'd0, 8'd0,   16'hF800, 12, 5,  BRD,     0};
    vecs[20] = '{2'd1, 8'd100, 16'hF800, 12, 6,  12'h000, 0};
    vecs[21] = '{2'd0, 8'd0,   16'hF800, 20, 9,  BRD,     31};

    step(3);
    chk("rst_hcnt", {22'd0, HCnt}, 0);
    chk("rst_vcnt", {22'd0, VCnt}, 0);
    chk("rst_addr", {15'd0, frame_addr}, 0);
    rgb_chk("rst_rgb", 12'h000);
    chk("rst_hsync", {31'd0, vga_hsync}, 1);
    chk("rst_vsync", {31'd0, vga_vsync}, 1);
    chk("rst_fstart", {31'd0, frame_start}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_fstart", {31'd0, frame_start}, 1);
    step(1);
    chk("rel_hcnt1", {22'd0, HCnt}, 1);

    hs_low = 0;
    vs_low = 0;
    fs_at  = -1;
    for (int k = 0; k < HT * VT; k++) begin
      if (!vga_hsync) hs_low++;
      if (!vga_vsync) vs_low++;
      if (frame_start && fs_at < 0) fs_at = k + 1;
      step(1);
    end
    chk("hsync_low_cycles", hs_low, HS * VT);
    chk("vsync_low_cycles", vs_low, VS * HT);
    chk("frame_period", fs_at, HT * VT);

    next_pos(37, 3); chk("hs_edge_37", {31'd0, vga_hsync}, 1);
    next_pos(38, 3); chk("hs_edge_38", {31'd0, vga_hsync}, 0);
    next_pos(43, 3); chk("hs_edge_43", {31'd0, vga_hsync}, 0);
    next_pos(44, 3); chk("hs_edge_44", {31'd0, vga_hsync}, 1);
    next_pos(1, 18); chk("vs_edge_1_18", {31'd0, vga_vsync}, 1);
    next_pos(2, 18); chk("vs_edge_2_18", {31'd0, vga_vsync}, 0);
    next_pos(1, 20); chk("vs_edge_1_20", {31'd0, vga_vsync}, 0);
    next_pos(2, 20); chk("vs_edge_2_20", {31'd0, vga_vsync}, 1);

    for (int i = 0; i < 22; i++) begin
      mode        = vecs[i].m;
      threshold   = vecs[i].t;
      frame_pixel = vecs[i].p;
      next_pos(0, 0);
      wait_pos(vecs[i].h, vecs[i].v);
      chk($sformatf("vec%0d_addr", i), {15'd0, frame_addr}, vecs[i].a);
      step(2);
      rgb_chk($sformatf("vec%0d_rgb", i), vecs[i].rgb);
    end

    mode        = 2'd0;
    threshold   = 8'd0;
    frame_pixel = 16'hF800;
    next_pos(0, 0);
    wait_pos(13, 7);
    step(1);
    rgb_chk("lat_before", 12'hF00);
    frame_pixel = 16'h001F;
    step(1);
    rgb_chk("lat_t2", 12'h00F);
    frame_pixel = 16'hF800;
    step(1);
    rgb_chk("lat_t3", 12'hF00);

    next_pos(0, 0);
    wait_pos(12, 8);
    mode      = 2'd1;
    threshold = 8'd100;
    wait_pos(13, 9);
    step(2);
    rgb_chk("midframe_still_colour", 12'hF00);
    next_pos(0, 0);
    wait_pos(12, 6);
    step(2);
    rgb_chk("nextframe_binary", 12'h000);

    reset_at(40, 19, "rst_sync");
    mode = 2'd0;
    next_pos(0, 0);
    wait_pos(13, 8);
    step(1);
    rgb_chk("pre_rst_rgb", 12'hF00);
    reset_at(14, 8, "rst_pix");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
